// File: rtl/tile_pkg.sv
// Shared tile codes, grid geometry, requester ids and scheduler state type
// for the live tile map and its writers.
package tile_pkg;

    localparam logic [2:0] FREE = 3'd0;
    localparam logic [2:0] REGU = 3'd1;
    localparam logic [2:0] GATE = 3'd2;
    localparam logic [2:0] COIN = 3'd3;
    localparam logic [2:0] PORT = 3'd4;
    localparam logic [2:0] SPIK = 3'd5;
    localparam logic [2:0] BRAK = 3'd6;

    localparam int DEF_ROWS    = 7;
    localparam int DEF_COLS    = 10;
    localparam int DEF_NUM_REQ = 3;

    localparam int ROW_W  = 3;
    localparam int COL_W  = 4;
    localparam int TILE_W = 3;
    localparam int LVL_W  = 2;
    localparam int IDX_W  = 7;

    localparam int REQ_COIN  = 0;
    localparam int REQ_BRICK = 1;
    localparam int REQ_GATE  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/tile_write_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant starting at the
// registered pointer; the pointer moves past the winner only on a grant.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW:0]   w_sum  [N];
    logic [PW-1:0] w_cand [N];
    logic [PW-1:0] w_win;
    logic          w_any;
    logic [N-1:0]  w_grant;

    // w_cand[k] is the requester examined k-th, i.e. (ptr + k) mod N.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, r_ptr} + (PW+1)'(gi);
            assign w_cand[gi] = (w_sum[gi] >= (PW+1)'(N)) ?
                                PW'(w_sum[gi] - (PW+1)'(N)) : w_sum[gi][PW-1:0];
        end
    endgenerate

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_any && i_req[w_cand[k]]) begin
                w_any = 1'b1;
                w_win = w_cand[k];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (i_en && w_any) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign o_grant = w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en && w_any) begin
            r_ptr <= (w_win == PW'(N-1)) ? '0 : w_win + 1'b1;
        end
    end

endmodule

// File: rtl/tile_write_scheduler.sv
// Sole writer of the live tile map: sweeps a level's ROM image on load, then
// round-robins single-tile gameplay updates onto the one map write port.
module tile_write_scheduler
    import tile_pkg::*;
#(
    parameter int NUM_OF_ROWS = DEF_ROWS,
    parameter int NUM_OF_COLS = DEF_COLS,
    parameter int NUM_REQ     = DEF_NUM_REQ
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_lvl,
    input  logic [LVL_W-1:0]          lvl,
    output logic [LVL_W-1:0]          rom_lvl,
    output logic [ROW_W-1:0]          rom_row,
    output logic [COL_W-1:0]          rom_col,
    input  logic [TILE_W-1:0]         rom_tile,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ROW_W-1:0]  req_row,
    input  logic [NUM_REQ*COL_W-1:0]  req_col,
    input  logic [NUM_REQ*TILE_W-1:0] req_tile,
    output logic                      wr_en,
    output logic [ROW_W-1:0]          wr_row,
    output logic [COL_W-1:0]          wr_col,
    output logic [TILE_W-1:0]         wr_tile,
    output logic                      busy,
    output logic                      load_done,
    output logic                      err_oob
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_ROWS*NUM_OF_COLS - 1);
    localparam logic [IDX_W-1:0] DONE_IDX = IDX_W'(NUM_OF_ROWS*NUM_OF_COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_OF_COLS - 1);

    sched_state_t        r_state, w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic [LVL_W-1:0]    r_rom_lvl;
    logic                r_wr_en, r_wr_from_rom;
    logic [ROW_W-1:0]    r_wr_row;
    logic [COL_W-1:0]    r_wr_col;
    logic [TILE_W-1:0]   r_wr_tile;
    logic                r_load_done, r_err_oob;

    logic                w_arb_en, w_hs, w_oob;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ROW_W-1:0]    w_sel_row;
    logic [COL_W-1:0]    w_sel_col;
    logic [TILE_W-1:0]   w_sel_tile;

    // A load request outranks gameplay updates in the same cycle.
    assign w_arb_en = (r_state == S_RUN) && !load_lvl && !reset;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (req_valid),
        .i_en    (w_arb_en),
        .o_grant (w_grant)
    );

    always_comb begin
        w_sel_row  = '0;
        w_sel_col  = '0;
        w_sel_tile = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_row  = req_row[i*ROW_W +: ROW_W];
                w_sel_col  = req_col[i*COL_W +: COL_W];
                w_sel_tile = req_tile[i*TILE_W +: TILE_W];
            end
        end
    end

    assign w_hs  = |(w_grant & req_valid);
    assign w_oob = (int'(w_sel_row) >= NUM_OF_ROWS) || (int'(w_sel_col) >= NUM_OF_COLS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (load_lvl) w_state_next = S_LOAD;
            S_LOAD: begin
                if (load_lvl) begin
                    w_state_next = S_LOAD;
                end else if (r_idx == DONE_IDX) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN:  if (load_lvl) w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_rom_lvl     <= '0;
            r_wr_en       <= 1'b0;
            r_wr_from_rom <= 1'b0;
            r_wr_row      <= '0;
            r_wr_col      <= '0;
            r_wr_tile     <= '0;
            r_load_done   <= 1'b0;
            r_err_oob     <= 1'b0;
        end else begin
            r_wr_en       <= 1'b0;
            r_wr_from_rom <= 1'b0;
            r_load_done   <= 1'b0;
            r_err_oob     <= 1'b0;
            if (load_lvl) begin
                // Restarting drops the ROM word still in flight.
                r_rom_lvl <= lvl;
                r_idx     <= '0;
                r_row     <= '0;
                r_col     <= '0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (r_idx == DONE_IDX) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_wr_en       <= 1'b1;
                            r_wr_from_rom <= 1'b1;
                            r_wr_row      <= r_row;
                            r_wr_col      <= r_col;
                            r_idx         <= r_idx + 1'b1;
                            if (r_idx != LAST_IDX) begin
                                if (r_col == LAST_COL) begin
                                    r_col <= '0;
                                    r_row <= r_row + 1'b1;
                                end else begin
                                    r_col <= r_col + 1'b1;
                                end
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_hs) begin
                            if (w_oob) begin
                                r_err_oob <= 1'b1;
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_row  <= w_sel_row;
                                r_wr_col  <= w_sel_col;
                                r_wr_tile <= w_sel_tile;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom_lvl   = r_rom_lvl;
    assign rom_row   = r_row;
    assign rom_col   = r_col;
    assign req_ready = w_grant;
    assign wr_en     = r_wr_en;
    assign wr_row    = r_wr_row;
    assign wr_col    = r_wr_col;
    // ROM data arrives alongside its write strobe, so it bypasses the register.
    assign wr_tile   = r_wr_from_rom ? rom_tile : r_wr_tile;
    assign busy      = (r_state == S_LOAD);
    assign load_done = r_load_done;
    assign err_oob   = r_err_oob;

endmodule

// File: tb/tb_tile_write_scheduler.sv
// Scoreboard bench: stimulus pushes expected map events tagged by cycle, a
// negedge monitor pops and compares them against the scheduler outputs.
module tb_tile_write_scheduler;
    import tile_pkg::*;

    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_lvl;
    logic [1:0]      lvl;
    logic [1:0]      rom_lvl;
    logic [2:0]      rom_row;
    logic [3:0]      rom_col;
    logic [2:0]      rom_tile;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*3-1:0] req_row;
    logic [NR*4-1:0] req_col;
    logic [NR*3-1:0] req_tile;
    logic            wr_en;
    logic [2:0]      wr_row;
    logic [3:0]      wr_col;
    logic [2:0]      wr_tile;
    logic            busy, load_done, err_oob;

    tile_write_scheduler dut (
        .clk(clk), .reset(reset), .load_lvl(load_lvl), .lvl(lvl),
        .rom_lvl(rom_lvl), .rom_row(rom_row), .rom_col(rom_col), .rom_tile(rom_tile),
        .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
        .req_col(req_col), .req_tile(req_tile), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_tile(wr_tile), .busy(busy), .load_done(load_done),
        .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] rom_f(input int l, input int r, input int c);
        int v;
        v = l * 5 + r * 3 + c;
        return v[2:0];
    endfunction

    // Level ROM image with one cycle of read latency.
    always @(posedge clk) rom_tile <= rom_f(int'(rom_lvl), int'(rom_row), int'(rom_col));

    typedef struct { int cyc; int kind; int row; int col; int tile; } ev_t;  // kind 0 wr, 1 oob, 2 done
    typedef struct { int cyc; logic [NR-1:0] ready; logic busy; } ck_t;

    ev_t evq[$];
    ck_t ckq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_on  = 0;

    bit  pend [NR];
    int  prow [NR];
    int  pcol [NR];
    int  ptile[NR];
    bit  rand_en = 0, keep_full = 0;
    int  rr = 0;
    int  ls = -1000;
    bit  loaded = 0;

    task automatic new_req(input int i, input bit inr);
        if (inr) begin
            prow[i] = $urandom_range(0, 6);
            pcol[i] = $urandom_range(0, 9);
        end else begin
            prow[i] = $urandom_range(0, 7);
            pcol[i] = $urandom_range(0, 15);
        end
        ptile[i] = $urandom_range(0, 6);
    endtask

    task automatic set_req(input int i, input int r, input int c, input int t);
        pend[i] = 1'b1; prow[i] = r; pcol[i] = c; ptile[i] = t;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    endtask

    task automatic step(input bit do_load, input logic [1:0] l);
        logic [NR-1:0] exp_ready;
        logic          exp_busy;
        bit            run;
        int            w;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            if (rand_en) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i, $urandom_range(0, 5) != 0);
                    pend[i] = 1'b1;
                end
            end
            if (keep_full && !pend[i]) begin
                new_req(i, 1'b1);
                pend[i] = 1'b1;
            end
            req_valid[i]       = pend[i];
            req_row[i*3 +: 3]  = 3'(prow[i]);
            req_col[i*4 +: 4]  = 4'(pcol[i]);
            req_tile[i*3 +: 3] = 3'(ptile[i]);
        end
        load_lvl = do_load;
        lvl      = do_load ? l : 2'($urandom_range(0, 3));

        exp_busy  = (cyc >= ls + 1) && (cyc <= ls + 71);
        run       = loaded && (cyc >= ls + 72);
        exp_ready = '0;
        w         = -1;
        if (run && !do_load) begin
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && pend[(rr + k) % NR]) w = (rr + k) % NR;
            end
        end
        if (w >= 0) begin
            exp_ready[w] = 1'b1;
            if (prow[w] >= 7 || pcol[w] >= 10)
                evq.push_back('{cyc + 1, 1, prow[w], pcol[w], ptile[w]});
            else
                evq.push_back('{cyc + 1, 0, prow[w], pcol[w], ptile[w]});
            rr      = (w + 1) % NR;
            pend[w] = 1'b0;
        end
        ckq.push_back('{cyc, exp_ready, exp_busy});

        if (do_load) begin
            while (evq.size() > 0 && evq[$].cyc > cyc) void'(evq.pop_back());
            ls     = cyc;
            loaded = 1'b1;
            for (int i = 0; i < 70; i++)
                evq.push_back('{cyc + 2 + i, 0, i / 10, i % 10, int'(rom_f(int'(l), i / 10, i % 10))});
            evq.push_back('{cyc + 72, 2, 0, 0, 0});
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        ck_t ck;
        int  gk;
        if (mon_on) begin
            if (ckq.size() > 0 && ckq[0].cyc == cyc) begin
                ck = ckq.pop_front();
                n_tests++;
                if (req_ready !== ck.ready || busy !== ck.busy) begin
                    n_fail++;
                    $display("[TB] FAIL ready_busy cyc=%0d: got ready=%b busy=%b, want ready=%b busy=%b",
                             cyc, req_ready, busy, ck.ready, ck.busy);
                end
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                n_tests++;
                n_fail++;
                $display("[TB] FAIL missing_event cyc=%0d: got nothing, want kind=%0d (%0d,%0d)=%0d",
                         e.cyc, e.kind, e.row, e.col, e.tile);
            end
            if (wr_en || err_oob || load_done) begin
                gk = load_done ? 2 : (err_oob ? 1 : 0);
                n_tests++;
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    e = evq.pop_front();
                    if ((int'(wr_en) + int'(err_oob) + int'(load_done)) != 1 || gk != e.kind ||
                        (gk == 0 && (int'(wr_row) != e.row || int'(wr_col) != e.col ||
                                     int'(wr_tile) != e.tile))) begin
                        n_fail++;
                        $display("[TB] FAIL event cyc=%0d: got wr=%b oob=%b done=%b (%0d,%0d)=%0d, want kind=%0d (%0d,%0d)=%0d",
                                 cyc, wr_en, err_oob, load_done, wr_row, wr_col, wr_tile,
                                 e.kind, e.row, e.col, e.tile);
                    end else begin
                        $display("[TB] cyc=%0d kind=%0d (%0d,%0d)=%0d ok", cyc, gk, wr_row, wr_col, wr_tile);
                    end
                end else begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_event cyc=%0d: got wr=%b oob=%b done=%b (%0d,%0d)=%0d, want none",
                             cyc, wr_en, err_oob, load_done, wr_row, wr_col, wr_tile);
                end
            end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                n_tests++;
                n_fail++;
                $display("[TB] FAIL missing_event cyc=%0d: got nothing, want kind=%0d (%0d,%0d)=%0d",
                         cyc, e.kind, e.row, e.col, e.tile);
            end
        end
    end

    task automatic chk_zero(input string name, input int val);
        n_tests++;
        if (val != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_%s: got %0d, want 0", name, val);
        end
    endtask

    initial begin
        reset     = 1'b1;
        load_lvl  = 1'b1;
        lvl       = 2'd3;
        req_valid = '1;
        req_row   = '1;
        req_col   = '1;
        req_tile  = '1;
        clear_reqs();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rom_lvl", int'(rom_lvl));
        chk_zero("rom_row", int'(rom_row));
        chk_zero("rom_col", int'(rom_col));
        chk_zero("req_ready", int'(req_ready));
        chk_zero("wr_en", int'(wr_en));
        chk_zero("wr_row", int'(wr_row));
        chk_zero("wr_col", int'(wr_col));
        chk_zero("wr_tile", int'(wr_tile));
        chk_zero("busy", int'(busy));
        chk_zero("load_done", int'(load_done));
        chk_zero("err_oob", int'(err_oob));
        reset     = 1'b0;
        load_lvl  = 1'b0;
        req_valid = '0;
        mon_on    = 1'b1;

        // Full load of level 2, ending in the first RUN cycle.
        step(1'b1, 2'd2);
        repeat (72) step(1'b0, 2'd0);

        // All requesters continuously valid: grants rotate 0,1,2,0,1,2.
        keep_full = 1'b1;
        repeat (6) step(1'b0, 2'd0);
        keep_full = 1'b0;
        clear_reqs();
        step(1'b0, 2'd0);

        // Single brick request, then pointer check with 0 and 2 competing.
        set_req(REQ_BRICK, 3, 5, int'(FREE));
        step(1'b0, 2'd0);
        set_req(REQ_COIN, 1, 1, int'(FREE));
        set_req(REQ_GATE, 2, 2, int'(GATE));
        step(1'b0, 2'd0);
        step(1'b0, 2'd0);
        step(1'b0, 2'd0);

        // Out-of-range row is accepted and dropped.
        set_req(REQ_COIN, 7, 2, int'(GATE));
        step(1'b0, 2'd0);
        step(1'b0, 2'd0);
        step(1'b0, 2'd0);

        // Restart a load while idx 30 is on the ROM address.
        step(1'b1, 2'd3);
        repeat (30) step(1'b0, 2'd0);
        step(1'b1, 2'd1);
        repeat (72) step(1'b0, 2'd0);

        // Load pulse collides with a gate request; the request waits for RUN.
        set_req(REQ_GATE, 4, 4, int'(COIN));
        step(1'b1, 2'd0);
        repeat (72) step(1'b0, 2'd0);
        step(1'b0, 2'd0);

        // Randomized traffic with occasional level loads.
        rand_en = 1'b1;
        repeat (400) step($urandom_range(0, 199) == 0, 2'($urandom_range(0, 3)));
        rand_en = 1'b0;
        clear_reqs();
        repeat (80) step(1'b0, 2'd0);
        @(negedge clk);
        #1;

        n_tests++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expected events, want 0", evq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
